// File: rtl/clk_div_pkg.sv
// Shared constants, default channel state layout and the high-time clamp helper
// for the multi-channel clock divider.
package clk_div_pkg;

  localparam int MIN_DIV   = 2;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] count;
    logic [CNT_W_DEF-1:0] div_act;
    logic [CNT_W_DEF-1:0] high_act;
    logic [CNT_W_DEF-1:0] div_sh;
    logic [CNT_W_DEF-1:0] high_sh;
    logic                 pend;
  } chan_state_t;

  // High time can never exceed the period it lives in.
  function automatic logic [31:0] clamp_high(input logic [31:0] high, input logic [31:0] div);
    return (high > div) ? div : high;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active period+high registers, registered
// clk_out and tick. A load arriving on a wrap (or while disabled) goes straight to active.
module clk_div_chan #(
  parameter int CNT_W   = clk_div_pkg::CNT_W_DEF,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] ld_div,
  input  logic [CNT_W-1:0] ld_high,
  output logic             clk_out,
  output logic             tick
);

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] div_sh;
    logic [CNT_W-1:0] high_sh;
    logic             pend;
  } st_t;

  localparam st_t RST_ST = '{
    count:    CNT_W'(DEF_DIV - 1),
    div_act:  CNT_W'(DEF_DIV),
    high_act: CNT_W'(DEF_DIV >> 1),
    div_sh:   CNT_W'(DEF_DIV),
    high_sh:  CNT_W'(DEF_DIV >> 1),
    pend:     1'b0
  };

  st_t  st, nx;
  logic wrap, clk_nx;

  always_comb begin
    nx   = st;
    wrap = en && (sync || (st.count == st.div_act - CNT_W'(1)));
    if (!en || wrap) begin
      if (load) begin
        nx.div_act  = ld_div;
        nx.high_act = ld_high;
        nx.div_sh   = ld_div;
        nx.high_sh  = ld_high;
        nx.pend     = 1'b0;
      end else if (st.pend) begin
        nx.div_act  = st.div_sh;
        nx.high_act = st.high_sh;
        nx.pend     = 1'b0;
      end
    end else if (load) begin
      nx.div_sh  = ld_div;
      nx.high_sh = ld_high;
      nx.pend    = 1'b1;
    end
    // Disabled channels park one step before the wrap so re-enable starts a period.
    if (!en)       nx.count = nx.div_act - CNT_W'(1);
    else if (wrap) nx.count = '0;
    else           nx.count = st.count + CNT_W'(1);
    clk_nx = en && (nx.count < nx.high_act);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= RST_ST;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      st      <= nx;
      clk_out <= clk_nx;
      tick    <= wrap;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: shared write port with validation and
// ack/err pulses, one clk_div_chan per channel. CLK_DIV_MULTI_PHASE_ALIGN_EN adds sync_i.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [CNT_W-1:0]  wr_high,
`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
  input  logic              sync_i,
`endif
  output logic              wr_ack,
  output logic              wr_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic             wr_ok, sync;
  logic [CNT_W-1:0] high_c;

`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  assign wr_ok  = wr_en && (32'(wr_ch) < NUM_CH) && (32'(wr_div) >= MIN_DIV);
  assign high_c = CNT_W'(clamp_high(32'(wr_high), 32'(wr_div)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_ok;
      wr_err <= wr_en && !wr_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[g]),
      .sync    (sync),
      .load    (wr_ok && (wr_ch == 4'(g))),
      .ld_div  (wr_div),
      .ld_high (high_c),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (NUM_CH=2, CNT_W=8, DEF_DIV=4): period-level model
// checked every cycle, plus hand-computed waveform expectations.
module tb_clk_div_multi;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int DD  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_en;
  logic           wr_en;
  logic [3:0]     wr_ch;
  logic [CW-1:0]  wr_div, wr_high;
  logic           wr_ack, wr_err;
  logic [NCH-1:0] clk_out, tick;
`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
  logic           sync_i;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .wr_high (wr_high),
`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
    .sync_i  (sync_i),
`endif
    .wr_ack  (wr_ack),
    .wr_err  (wr_err),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel tracks its position inside the current period (0 = tick cycle),
  // the period/high in force and a pending pair waiting for the next period start.
  int             m_ph[NCH], m_div[NCH], m_high[NCH], m_sdiv[NCH], m_shigh[NCH];
  bit             m_pend[NCH];
  logic [NCH-1:0] e_clk, e_tick;
  logic           e_ack, e_err;
  bit             ok, hit, start, sy;
  int             nh;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_ph[i] = DD - 1; m_div[i] = DD; m_high[i] = DD / 2; m_pend[i] = 0;
      end
      e_clk = '0; e_tick = '0; e_ack = 0; e_err = 0;
    end else begin
      ok    = wr_en && (int'(wr_ch) < NCH) && (int'(wr_div) >= 2);
      e_ack = ok;
      e_err = wr_en && !ok;
      nh    = (int'(wr_high) > int'(wr_div)) ? int'(wr_div) : int'(wr_high);
`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
      sy = sync_i;
`else
      sy = 0;
`endif
      for (int i = 0; i < NCH; i++) begin
        hit   = ok && (int'(wr_ch) == i);
        start = ch_en[i] && (sy || m_ph[i] == m_div[i] - 1);
        if (!ch_en[i] || start) begin
          if (hit) begin
            m_div[i] = int'(wr_div); m_high[i] = nh; m_pend[i] = 0;
          end else if (m_pend[i]) begin
            m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
          end
        end else if (hit) begin
          m_sdiv[i] = int'(wr_div); m_shigh[i] = nh; m_pend[i] = 1;
        end
        if (!ch_en[i]) m_ph[i] = m_div[i] - 1;
        else if (start) m_ph[i] = 0;
        else m_ph[i] = m_ph[i] + 1;
        e_tick[i] = start;
        e_clk[i]  = ch_en[i] && (m_ph[i] < m_high[i]);
      end
    end
    #1;
    chk("m_ack", 32'(wr_ack), 32'(e_ack));
    chk("m_err", 32'(wr_err), 32'(e_err));
    chk("m_clk_out", 32'(clk_out), 32'(e_clk));
    chk("m_tick", 32'(tick), 32'(e_tick));
  end

  task automatic do_wr(input int ch, input int dv, input int hi);
    wr_en = 1'b1; wr_ch = 4'(ch); wr_div = CW'(dv); wr_high = CW'(hi);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  logic [7:0]  s0, s1;
  logic [11:0] s12;
  int          nt;

  initial begin
    rst_n = 0; ch_en = '0; wr_en = 0; wr_ch = '0; wr_div = '0; wr_high = '0;
`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
    sync_i = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ack_err", 32'({wr_ack, wr_err}), 0);

    // Default divide-by-4 from the first enabled cycle
    rst_n = 1; ch_en = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); s0[7-k] = clk_out[0]; s1[7-k] = tick[0];
    end
    chk("def_clk0", 32'(s0), 32'h0000_00CC);
    chk("def_tick0", 32'(s1), 32'h0000_0088);

    // Mid-period reprogram of ch1: current period finishes, then 1,1,0,0,0
    repeat (2) @(negedge clk);
    do_wr(1, 5, 2);
    chk("wr_ack", 32'({wr_ack, wr_err}), 32'h2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); s0[7-k] = clk_out[0]; s1[7-k] = clk_out[1];
    end
    chk("mid_clk1", 32'(s1), 32'h0000_0063);
    chk("mid_clk0", 32'(s0), 32'h0000_0066);

    // Rejected writes
    do_wr(0, 1, 0);
    chk("err_div1", 32'({wr_ack, wr_err}), 32'h1);
    do_wr(2, 5, 2);
    chk("err_ch2", 32'({wr_ack, wr_err}), 32'h1);

    // high=0: constant low, ticks continue
    do_wr(0, 4, 0);
    repeat (6) @(negedge clk);
    nt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); s0[7-k] = clk_out[0]; nt += int'(tick[0]);
    end
    chk("hi0_clk", 32'(s0), 0);
    chk("hi0_ticks", 32'(nt), 2);

    // high clamped to div: constant high
    do_wr(0, 6, 9);
    repeat (6) @(negedge clk);
    nt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); s12[11-k] = clk_out[0]; nt += int'(tick[0]);
    end
    chk("clamp_clk", 32'(s12), 32'h0000_0FFF);
    chk("clamp_ticks", 32'(nt), 2);

    // Enable drop during high phase, then re-raise
    ch_en = 2'b10;
    @(negedge clk);
    chk("dis_clk0", 32'(clk_out[0]), 0);
    repeat (2) @(negedge clk);
    ch_en = 2'b11;
    @(negedge clk);
    chk("reen_tick_clk", 32'({tick[0], clk_out[0]}), 32'h3);

    // Reset with a pending write: defaults return
    repeat (2) @(negedge clk);
    do_wr(1, 7, 3);
    rst_n = 0;
    @(negedge clk);
    chk("rst2_out", 32'({clk_out, tick, wr_ack, wr_err}), 0);
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); s1[7-k] = clk_out[1];
    end
    chk("rst2_clk1", 32'(s1), 32'h0000_00CC);

`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
    do_wr(0, 4, 2);
    do_wr(1, 6, 3);
    repeat (9) @(negedge clk);
    sync_i = 1;
    @(negedge clk);
    sync_i = 0;
    chk("sync_tick", 32'(tick), 32'h3);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("sync_t4", 32'(tick), 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("sync_t6", 32'(tick), 32'h2);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
